// File: rtl/instr_fetch.sv
// Two-byte instruction fetch: reads pc_in, bumps the PC via the ARF after each byte, holds the 16-bit word.
// Zero-wait latency is start edge N -> ir_valid from N+4; ir_q is held in HOLD until ir_ready; mem_ack stalls RD states.
module instr_fetch #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        flush,
    input  logic [7:0]  pc_in,
    output logic [7:0]  mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic [1:0]  arf_funsel,
    output logic [3:0]  arf_rsel,
    output logic [15:0] ir_q,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic        busy,
    output logic        err
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD0  = 3'd1;
    localparam logic [2:0] S_INC0 = 3'd2;
    localparam logic [2:0] S_RD1  = 3'd3;
    localparam logic [2:0] S_INC1 = 3'd4;
    localparam logic [2:0] S_HOLD = 3'd5;

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [2:0]    state_q, state_d;
    logic [15:0]   ir_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          in_rd, in_inc, timeout_hit;

    assign in_rd       = (state_q == S_RD0) || (state_q == S_RD1);
    assign in_inc      = (state_q == S_INC0) || (state_q == S_INC1);
    // The last permitted wait cycle; an ack arriving in it still wins over the abort.
    assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        err_d   = err_q;
        cnt_d   = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RD0;
                    err_d   = 1'b0;
                end
            end
            S_RD0, S_RD1: begin
                if (mem_ack) begin
                    if (state_q == S_RD0) begin
                        ir_d[7:0] = mem_rdata;
                        state_d   = S_INC0;
                    end else begin
                        ir_d[15:8] = mem_rdata;
                        state_d    = S_INC1;
                    end
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_INC0: state_d = S_RD1;
            S_INC1: state_d = S_HOLD;
            S_HOLD: begin
                if (ir_ready) begin
                    state_d = start ? S_RD0 : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Flush wins over everything: no capture, no error update.
        if (flush) begin
            state_d = S_IDLE;
            ir_d    = ir_q;
            err_d   = err_q;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ir_q    <= 16'h0000;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode straight from state so reset forces them immediately.
    assign mem_rd     = in_rd && !flush;
    assign mem_addr   = (in_rd && !flush) ? pc_in : 8'h00;
    assign arf_rsel   = (in_inc && !flush) ? 4'b0001 : 4'b0000;
    assign arf_funsel = (in_inc && !flush) ? 2'b11 : 2'b00;
    assign ir_valid   = (state_q == S_HOLD);
    assign busy       = (state_q != S_IDLE);
    assign err        = err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: ARF PC register and memory with programmable ack delay, checked against a per-fetch timing model.
module tb_instr_fetch;

    localparam int TO    = 16;
    localparam int NOACK = 200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic        ir_ready = 1'b0;
    logic [7:0]  pc_in, mem_addr, mem_rdata;
    logic        mem_rd, mem_ack;
    logic [1:0]  arf_funsel;
    logic [3:0]  arf_rsel;
    logic [15:0] ir_q;
    logic        ir_valid, busy, err;

    logic [7:0]  mem [256];
    logic [7:0]  pc = 8'h00;
    logic        pc_load = 1'b0;
    logic [7:0]  pc_load_val = 8'h00;
    logic [7:0]  cur_pc0 = 8'h00;
    logic [15:0] last_ir = 16'h0000;
    int          inc_cnt = 0;
    int          rd_cycles = 0;
    int          dly0 = 0;
    int          dly1 = 0;
    int          checks = 0;
    int          failures = 0;

    instr_fetch #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .pc_in(pc_in),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .arf_funsel(arf_funsel), .arf_rsel(arf_rsel), .ir_q(ir_q), .ir_valid(ir_valid),
        .ir_ready(ir_ready), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    assign pc_in = pc;

    // Memory acks the (delay+1)-th consecutive cycle of a read; byte 0 lives at cur_pc0.
    always_comb begin
        mem_rdata = mem[mem_addr];
        mem_ack   = mem_rd && (rd_cycles == ((mem_addr == cur_pc0) ? dly0 : dly1));
    end

    always @(posedge clk) begin
        if (pc_load) begin
            pc <= pc_load_val;
        end else if (arf_rsel == 4'b0001 && arf_funsel == 2'b11) begin
            pc      <= pc + 8'd1;
            inc_cnt <= inc_cnt + 1;
        end
        if (mem_rd && !mem_ack) rd_cycles <= rd_cycles + 1;
        else                    rd_cycles <= 0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_outs();
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_arf_rsel", arf_rsel, 0);
        chk("rst_arf_funsel", arf_funsel, 0);
        chk("rst_ir_q", ir_q, 0);
        chk("rst_ir_valid", ir_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
    endtask

    // Expected per-cycle bus activity k cycles after the start edge, given per-byte ack delays.
    function automatic void cyc_exp(input int k, input int d0, input int d1,
                                    output logic rd, output logic inc, output logic [7:0] aoff);
        int w0, w1;
        w0   = (d0 < TO) ? d0 : TO - 1;
        w1   = (d1 < TO) ? d1 : TO - 1;
        rd   = (k <= w0);
        inc  = 1'b0;
        aoff = (k <= d0) ? 8'd0 : 8'd1;
        if (d0 < TO) begin
            inc = (k == d0 + 1);
            rd  = rd || (k >= d0 + 2 && k <= d0 + 2 + w1);
            if (d1 < TO) inc = inc || (k == d0 + 3 + d1);
        end
    endfunction

    task automatic pulse_start(input logic [7:0] p0);
        pc_load_val = p0;
        pc_load     = 1'b1;
        @(negedge clk);
        pc_load = 1'b0;
        chk("idle_before_start", busy, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // end_mode: 0 release to IDLE, 1 release with start (back-to-back), 2 flush in HOLD
    task automatic fetch(input logic [7:0] p0, input int d0, input int d1, input bit chained,
                         input int bp, input int end_mode, output bit ok);
        int k, exp_k, exp_inc, inc0;
        logic erd, einc;
        logic [7:0] aoff, ea, p1, pc_exp;
        ok      = (d0 < TO) && (d1 < TO);
        exp_inc = (d0 >= TO) ? 0 : (d1 >= TO) ? 1 : 2;
        exp_k   = (d0 >= TO) ? TO : (d1 >= TO) ? d0 + 2 + TO : d0 + d1 + 4;
        p1      = p0 + 8'd1;
        cur_pc0 = p0;
        dly0    = d0;
        dly1    = d1;
        inc0    = inc_cnt;
        if (!chained) pulse_start(p0);
        k = 0;
        forever begin
            cyc_exp(k, d0, d1, erd, einc, aoff);
            chk("mem_rd", mem_rd, erd);
            chk("arf_rsel", arf_rsel, einc ? 4'b0001 : 4'b0000);
            chk("arf_funsel", arf_funsel, einc ? 2'b11 : 2'b00);
            if (erd) begin
                ea = p0 + aoff;
                chk("mem_addr", mem_addr, ea);
            end
            if (k == 0) chk("err_cleared", err, 0);
            if (ir_valid || !busy || k >= 100) break;
            @(negedge clk);
            k++;
        end
        if (d0 < TO) last_ir[7:0] = mem[p0];
        if (ok) last_ir[15:8] = mem[p1];
        pc_exp = p0 + exp_inc[7:0];
        chk("latency", k, exp_k);
        chk("err", err, !ok);
        chk("inc_pulses", inc_cnt - inc0, exp_inc);
        chk("pc", pc, pc_exp);
        chk("ir_valid", ir_valid, ok);
        chk("busy", busy, ok);
        chk("ir_q", ir_q, last_ir);
        if (ok) begin
            for (int i = 0; i < bp; i++) begin
                @(negedge clk);
                chk("hold_valid", ir_valid, 1);
                chk("hold_ir_q", ir_q, last_ir);
            end
            if (end_mode == 2) begin
                flush = 1'b1; ir_ready = 1'b1; start = 1'b1;
                #1 chk("hold_flush_mem_rd", mem_rd, 0);
                @(negedge clk);
                flush = 1'b0; ir_ready = 1'b0; start = 1'b0;
                chk("hold_flush_valid", ir_valid, 0);
                chk("hold_flush_busy", busy, 0);
                chk("hold_flush_ir_q", ir_q, last_ir);
                chk("hold_flush_err", err, 0);
            end else begin
                ir_ready = 1'b1;
                start    = (end_mode == 1);
                @(negedge clk);
                ir_ready = 1'b0;
                start    = 1'b0;
                if (end_mode == 0) begin
                    chk("release_busy", busy, 0);
                    chk("release_valid", ir_valid, 0);
                end
            end
        end
    endtask

    task automatic flush_inc0(input logic [7:0] p0);
        int inc0;
        cur_pc0 = p0; dly0 = 0; dly1 = 0;
        inc0 = inc_cnt;
        pulse_start(p0);
        @(negedge clk);
        chk("inc0_reached", arf_rsel, 4'b0001);
        flush = 1'b1;
        #1;
        chk("flush_rsel", arf_rsel, 4'b0000);
        chk("flush_funsel", arf_funsel, 2'b00);
        chk("flush_mem_rd", mem_rd, 0);
        @(negedge clk);
        flush = 1'b0;
        last_ir[7:0] = mem[p0];
        chk("flush_busy", busy, 0);
        chk("flush_valid", ir_valid, 0);
        chk("flush_inc", inc_cnt - inc0, 0);
        chk("flush_pc", pc, p0);
        chk("flush_ir_q", ir_q, last_ir);
        chk("flush_err", err, 0);
    endtask

    task automatic reset_in_rd1(input logic [7:0] p0);
        int inc0;
        logic [7:0] pc_exp;
        cur_pc0 = p0; dly0 = 0; dly1 = NOACK;
        inc0 = inc_cnt;
        pulse_start(p0);
        repeat (3) @(negedge clk);
        chk("rd1_active", mem_rd, 1);
        #2 rst_n = 1'b0;
        #1 chk_reset_outs();
        repeat (2) @(negedge clk);
        chk("rst_hold_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);
        last_ir = 16'h0000;
        pc_exp  = p0 + 8'd1;
        chk("post_rst_busy", busy, 0);
        chk("post_rst_valid", ir_valid, 0);
        chk("post_rst_inc", inc_cnt - inc0, 1);
        chk("post_rst_pc", pc, pc_exp);
    endtask

    function automatic int pick();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7)  return $urandom_range(0, 3);
        if (r == 7) return TO - 1;
        if (r == 8) return TO;
        return $urandom_range(4, TO + 4);
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok, chained_n;
        int d0, d1, bp, mode;
        logic [7:0] rp;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h10] = 8'hAB;
        mem[8'h11] = 8'hCD;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outs();
        rst_n = 1'b1;
        @(negedge clk);

        fetch(8'h10, 0, 0, 1'b0, 0, 0, ok);
        chk("ir_cdab", ir_q, 16'hCDAB);
        fetch(8'h10, 3, 3, 1'b0, 0, 0, ok);
        fetch(8'h10, 0, 0, 1'b0, 5, 1, ok);
        fetch(8'h12, 1, 0, 1'b1, 0, 0, ok);
        fetch(8'h20, 0, NOACK, 1'b0, 0, 0, ok);
        fetch(8'h30, 0, 0, 1'b0, 0, 0, ok);
        fetch(8'h40, TO - 1, TO - 1, 1'b0, 0, 0, ok);
        fetch(8'h44, TO, 0, 1'b0, 0, 0, ok);
        flush_inc0(8'h50);
        fetch(8'hFF, 1, 2, 1'b0, 0, 0, ok);
        fetch(8'h60, 0, 0, 1'b0, 2, 2, ok);
        reset_in_rd1(8'h70);
        fetch(8'h80, 0, 1, 1'b0, 0, 0, ok);

        chained_n = 1'b0;
        rp = 8'h00;
        for (int t = 0; t < 40; t++) begin
            d0 = pick();
            d1 = pick();
            bp = $urandom_range(0, 3);
            mode = $urandom_range(0, 2);
            if (t == 39 || d0 >= TO || d1 >= TO) mode = 0;
            if (!chained_n) rp = 8'($urandom);
            fetch(rp, d0, d1, chained_n, bp, mode, ok);
            chained_n = ok && (mode == 1);
            rp = rp + 8'd2;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have one parameter: TIMEOUT, default 16, the number of cycles to wait for mem_ack in a read state before aborting.
REQ-002 The block SHALL have these ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  request to fetch the next instruction.
- flush  in  1  abort the current fetch and discard any held instruction.
- pc_in  in  8  current PC, taken from the ARF out_b port with out_b_sel = 2'b11.
- mem_addr  out  8  memory byte address.
- mem_rd  out  1  memory read request.
- mem_rdata  in  8  memory read data; valid only when mem_ack = 1.
- mem_ack  in  1  memory read complete.
- arf_funsel  out  2  drives ARF funsel.
- arf_rsel  out  4  drives ARF r_sel, bit order {AR, SP, PC_past, PC}.
- ir_q  out  16  assembled instruction.
- ir_valid  out  1  ir_q holds a complete instruction.
- ir_ready  in  1  decoder consumes ir_q.
- busy  out  1  state is not IDLE.
- err  out  1  sticky memory-timeout flag.

Function
REQ-003 The FSM SHALL have the states IDLE, RD0, INC0, RD1, INC1, HOLD.
REQ-004 IDLE: when start = 1, the FSM SHALL go to RD0 and clear err on the same edge.
REQ-005 RD0/RD1: mem_rd SHALL be 1 and mem_addr SHALL be pc_in.
REQ-006 RD0/RD1: on mem_ack = 1, the block SHALL capture mem_rdata (RD0 into ir_q[7:0], RD1 into ir_q[15:8]) and go to INC0/INC1 respectively.
REQ-007 INC0/INC1: for exactly one cycle, the block SHALL drive arf_rsel = 4'b0001 and arf_funsel = 2'b11 (increment), so the PC advances on the exiting edge.
- INC0 SHALL then go to RD1.
- INC1 SHALL then go to HOLD.
REQ-008 In all states other than INC0/INC1, the block SHALL drive arf_rsel = 4'b0000 and arf_funsel = 2'b00; the ARF SHALL never be written outside INC states.
REQ-009 HOLD: ir_valid SHALL be 1 and ir_q SHALL be stable; on ir_ready = 1 the FSM SHALL go to RD0 if start = 1, otherwise to IDLE.
REQ-010 ir_valid SHALL be 1 only in HOLD; start SHALL be ignored in every state except IDLE and HOLD (with ir_ready = 1 in HOLD).
REQ-011 mem_ack SHALL be ignored outside RD0/RD1.
REQ-012 mem_ack arriving in the same cycle mem_rd rises SHALL be accepted (zero-wait memory).
REQ-013 Latency with zero-wait memory SHALL be as follows: start sampled at edge N gives ir_valid = 1 from cycle N+4 (states RD0, INC0, RD1, INC1, then HOLD).
REQ-014 Timeout: a counter SHALL count cycles spent in the current RD state without mem_ack and reset on entry to each RD state. If TIMEOUT cycles elapse without ack:
- the FSM SHALL go to IDLE;
- err SHALL be set to 1;
- no increment SHALL be issued.
REQ-015 An ack in the same cycle the counter reaches TIMEOUT SHALL win: the byte is captured and no error is raised.
REQ-016 flush = 1 in any state SHALL force IDLE on the next edge and override every other transition.
- In the flush cycle, arf_rsel SHALL be forced to 4'b0000 (no PC increment) and mem_rd SHALL be forced to 0.
- ir_valid SHALL be 0 from the next cycle.
- ir_q SHALL keep its value.
- err SHALL be unchanged.
REQ-017 A flush issued between INC0 and INC1 SHALL leave the PC advanced by one; re-alignment is the control unit's responsibility.
REQ-018 busy SHALL be 1 in every state except IDLE.
REQ-019 PC wrap SHALL be handled by the ARF (8'hFF + 1 = 8'h00); the block SHALL treat pc_in as opaque and apply no range checks.

Reset
REQ-020 While rst_n = 0, the block SHALL asynchronously force the following reset values:
- state IDLE;
- ir_q 16'h0000;
- ir_valid 0;
- err 0;
- timeout counter 0;
- mem_rd 0;
- mem_addr 8'h00;
- arf_rsel 4'b0000;
- arf_funsel 2'b00;
- busy 0.
REQ-021 Reset deassertion mid-fetch SHALL resume from IDLE, with no partial ARF write and no stale ir_valid.

Verification
REQ-022 The bench SHALL cover these scenarios:
- Zero-wait fetch: pc_in = 8'h10, memory [10] = 8'hAB, [11] = 8'hCD, start pulse -> ir_valid at cycle N+4, ir_q = 16'hCDAB, exactly two INC pulses with arf_rsel = 4'b0001.
- Wait states: ack delayed 3 cycles per byte -> ir_valid at N+10, mem_addr stable while mem_rd = 1, same ir_q.
- Back-pressure and back-to-back: ir_ready held 0 for 5 cycles -> ir_q and ir_valid stable; then ir_ready = 1 with start = 1 -> RD0 on the next cycle with no IDLE gap.
- Timeout: no ack in RD1 -> IDLE after 16 cycles, err = 1, exactly one INC issued; next start clears err.
- Flush in INC0 -> no PC increment that cycle, IDLE next, ir_valid = 0, busy = 0.
- Wrap: pc_in = 8'hFF -> bytes read from 8'hFF and 8'h00.
- Async reset asserted in RD1 -> all outputs take reset values immediately, before the next clock edge.
